binary_countdown_saturated: RTL and testbench
=============================================

BINARY_COUNTDOWN_SATURATED -- requirements
Module: binary_countdown_saturated

Interface
REQ-001 Parameter MAX_COUNT, default 100, prescale period in enabled clock cycles per LED decrement; legal range 1..2^32-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 load  input  1  when high, loads load_value into leds.
REQ-005 load_value  input  8  value loaded into leds.
REQ-006 start  input  1  begins countdown from IDLE.
REQ-007 pause  input  1  freezes prescaler and leds while RUN.
REQ-008 leds  output  8  current count value, registered.
REQ-009 busy  output  1  high while state is RUN, registered.
REQ-010 done  output  1  single-cycle expiry pulse, registered.

Function
REQ-011 The block SHALL implement a 3-state FSM: IDLE, RUN, EXPIRED.
REQ-012 The block SHALL hold a 32-bit prescaler that is cleared on every state entry and on every load.
REQ-013 In RUN with pause=0, each edge SHALL increment the prescaler, except when it equals MAX_COUNT-1: then it SHALL clear to 0 and leds SHALL decrement by 1.
REQ-014 The first decrement after start SHALL occur exactly MAX_COUNT un-paused edges after the edge that sampled start.
REQ-015 In RUN with pause=1, the prescaler, leds and state SHALL hold; busy SHALL stay 1.
REQ-016 A decrement from 1 to 0 SHALL move the FSM to EXPIRED on the same edge, deassert busy and assert done for exactly one cycle (the first cycle leds reads 0).
REQ-017 leds SHALL saturate at 0 and never wrap to 255; in EXPIRED leds SHALL hold 0 and done SHALL stay 0 after its pulse.
REQ-018 load=1 in any state SHALL set leds to load_value, clear the prescaler, force IDLE, drop busy and suppress done on that edge.
REQ-019 load SHALL take priority over start and over a same-edge decrement.
REQ-020 start=1 in IDLE with leds != 0 SHALL move to RUN; busy SHALL read 1 from the next cycle.
REQ-021 start in IDLE with leds=0 SHALL be ignored: state stays IDLE and done stays 0.
REQ-022 start in RUN or EXPIRED SHALL be ignored; only load exits EXPIRED.
REQ-023 With MAX_COUNT=1, leds SHALL decrement on every un-paused edge in RUN.
REQ-024 done and busy SHALL never be high in the same cycle.

Reset
REQ-025 rst=1 SHALL on the next edge force leds=0, prescaler=0, state=IDLE, busy=0, done=0.
REQ-026 rst SHALL take priority over load, start and pause.
REQ-027 After rst deasserts, the block SHALL stay in IDLE until load/start per REQ-018 and REQ-020.

Verification (MAX_COUNT=4 unless noted)
REQ-028 rst, then load 3, then start -> leds steps 3,2,1,0 at 4, 8 and 12 edges after start; busy falls and done pulses one cycle at leds=0.
REQ-029 load 2, start, then pause=1 for 10 cycles after 2 edges -> leds holds 2 during pause; leds reaches 0 exactly 8 un-paused edges after start.
REQ-030 load 9, start, run 6 edges, then load 5 -> next cycle leds=5, state IDLE, busy=0, done=0; a new start takes 20 edges to reach 0.
REQ-031 rst, start with leds=0 -> state stays IDLE, busy=0, done=0 for 20 cycles.
REQ-032 rst and load (value 7) asserted on the same edge mid-RUN -> leds=0, busy=0, done=0 next cycle.
REQ-033 MAX_COUNT=1, load 255, start -> leds reaches 0 after 255 edges, done pulses once, leds stays 0 (no wrap) for 10 further cycles.

Source files
------------

// File: rtl/binary_countdown_saturated_if.sv
// Control/status bundle for binary_countdown_saturated.
// All signals are level-sampled on the rising clock edge; there is no valid/ready
// handshake: load/start/pause act on every edge they are high, and leds/busy/done are registered.
interface binary_countdown_saturated_if;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic       pause;
    logic [7:0] leds;
    logic       busy;
    logic       done;

    modport master (
        output load, load_value, start, pause,
        input  leds, busy, done
    );

    modport slave (
        input  load, load_value, start, pause,
        output leds, busy, done
    );
endinterface

// File: rtl/binary_countdown_saturated.sv
// Prescaled 8-bit countdown that saturates at zero, with start/pause/load control,
// a registered busy flag and a one-cycle done pulse on expiry.
module binary_countdown_saturated #(
    parameter int unsigned MAX_COUNT = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    binary_countdown_saturated_if.slave   bus,
    output logic [1:0]                    state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    localparam logic [31:0] LAST_TICK = 32'(MAX_COUNT - 1);

    state_e      state_q, state_d;
    logic [31:0] prescale_q, prescale_d;
    logic [7:0]  leds_q, leds_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prescale_q <= '0;
            leds_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            leds_q     <= leds_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        leds_d     = leds_q;
        done_d     = 1'b0;

        if (bus.load) begin
            // load overrides everything, including a decrement due on this edge
            leds_d     = bus.load_value;
            prescale_d = '0;
            state_d    = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && (leds_q != 8'd0)) begin
                        state_d    = RUN;
                        prescale_d = '0;
                    end
                end
                RUN: begin
                    if (!bus.pause) begin
                        if (prescale_q == LAST_TICK) begin
                            prescale_d = '0;
                            if (leds_q != 8'd0) begin
                                leds_d = leds_q - 8'd1;
                            end
                            if (leds_q <= 8'd1) begin
                                state_d = EXPIRED;
                                done_d  = 1'b1;
                            end
                        end else begin
                            prescale_d = prescale_q + 32'd1;
                        end
                    end
                end
                EXPIRED: begin
                    leds_d     = '0;
                    prescale_d = '0;
                end
                default: begin
                    state_d    = IDLE;
                    prescale_d = '0;
                end
            endcase
        end

        busy_d = (state_d == RUN);
    end

    assign bus.leds = leds_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_binary_countdown_saturated.sv
// Bench for binary_countdown_saturated: MAX_COUNT=4 and MAX_COUNT=1 instances driven in lockstep
// and compared against an elapsed-time model of the countdown.
module tb_binary_countdown_saturated;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  binary_countdown_saturated_if bus0 ();
  binary_countdown_saturated_if bus1 ();
  logic [1:0] state0, state1;

  binary_countdown_saturated #(.MAX_COUNT(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_o(state0)
  );
  binary_countdown_saturated #(.MAX_COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_o(state1)
  );

  // ---------------- reference model ----------------
  // leds = base - floor(elapsed / M); expiry when elapsed reaches base*M.
  int unsigned mc[2] = '{4, 1};
  int unsigned m_base[2];
  int unsigned m_el[2];
  logic [7:0]  m_leds[2];
  bit          m_run[2];
  bit          m_exp[2];
  bit          m_done[2];

  int n_checks = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  task automatic model_edge(input int k, input logic r, input logic l, input logic [7:0] v,
                            input logic s, input logic p);
    m_done[k] = 1'b0;
    if (r) begin
      m_leds[k] = 8'd0; m_run[k] = 1'b0; m_exp[k] = 1'b0;
    end else if (l) begin
      m_leds[k] = v; m_run[k] = 1'b0; m_exp[k] = 1'b0;
    end else if (m_run[k]) begin
      if (!p) begin
        m_el[k] = m_el[k] + 1;
        m_leds[k] = 8'(m_base[k] - m_el[k] / mc[k]);
        if (m_el[k] == m_base[k] * mc[k]) begin
          m_run[k] = 1'b0; m_exp[k] = 1'b1; m_done[k] = 1'b1;
        end
      end
    end else if (!m_exp[k] && s && m_leds[k] != 8'd0) begin
      m_run[k] = 1'b1; m_base[k] = m_leds[k]; m_el[k] = 0;
    end
  endtask

  function automatic logic [11:0] model_pack(input int k);
    logic [1:0] st;
    st = m_run[k] ? 2'd1 : (m_exp[k] ? 2'd2 : 2'd0);
    return {st, m_run[k], m_done[k], m_leds[k]};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic compare_dut(input int k, input logic [1:0] st, input logic [7:0] leds,
                             input logic busy, input logic done);
    logic [11:0] e;
    e = exp_q.pop_front();
    check($sformatf("d%0d_leds", k), 32'(leds), 32'(e[7:0]));
    check($sformatf("d%0d_busy", k), 32'(busy), 32'(e[9]));
    check($sformatf("d%0d_done", k), 32'(done), 32'(e[8]));
    check($sformatf("d%0d_state", k), 32'(st), 32'(e[11:10]));
    check($sformatf("d%0d_busy_and_done", k), 32'(busy & done), 32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic l, input logic [7:0] v,
                      input logic s, input logic p);
    rst = r;
    bus0.load = l; bus0.load_value = v; bus0.start = s; bus0.pause = p;
    bus1.load = l; bus1.load_value = v; bus1.start = s; bus1.pause = p;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      model_edge(k, r, l, v, s, p);
      exp_q.push_back(model_pack(k));
    end
    #1;
    compare_dut(0, state0, bus0.leds, bus0.busy, bus0.done);
    compare_dut(1, state1, bus1.leds, bus1.busy, bus1.done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus0.load = 1'b0; bus0.load_value = '0; bus0.start = 1'b0; bus0.pause = 1'b0;
    bus1.load = 1'b0; bus1.load_value = '0; bus1.start = 1'b0; bus1.pause = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_leds[k] = 'x; m_run[k] = 0; m_exp[k] = 0; m_done[k] = 0; m_base[k] = 0; m_el[k] = 0;
    end

    // reset
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd7, 1'b1, 1'b0);
    check("reset_leds", 32'(bus0.leds), 32'd0);

    // load 3, start: steps at 4, 8, 12 edges
    step(1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check("start_busy", 32'(bus0.busy), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      if (i == 3) check("before_first_dec", 32'(bus0.leds), 32'd3);
      if (i == 4) check("first_dec", 32'(bus0.leds), 32'd2);
      if (i == 8) check("second_dec", 32'(bus0.leds), 32'd1);
    end
    check("expire_leds", 32'(bus0.leds), 32'd0);
    check("expire_done", 32'(bus0.done), 32'd1);
    check("expire_busy", 32'(bus0.busy), 32'd0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check("done_one_cycle", 32'(bus0.done), 32'd0);
    check("start_ignored_expired", 32'(state0), 32'd2);
    idle(3);

    // load 2, start, pause for 10 after 2 edges
    step(1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
      check("pause_hold", 32'(bus0.leds), 32'd2);
    end
    idle(5);
    check("pause_not_yet", 32'(bus0.leds), 32'd1);
    idle(1);
    check("pause_reach_zero", 32'(bus0.leds), 32'd0);
    idle(2);

    // load 9, start, 6 edges, reload 5; restart takes 20 edges
    step(1'b0, 1'b1, 8'd9, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    idle(6);
    step(1'b0, 1'b1, 8'd5, 1'b1, 1'b0);
    check("reload_leds", 32'(bus0.leds), 32'd5);
    check("reload_state", 32'(state0), 32'd0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    idle(19);
    check("restart_19", 32'(bus0.leds), 32'd1);
    idle(1);
    check("restart_20", 32'(bus0.leds), 32'd0);
    check("restart_done", 32'(bus0.done), 32'd1);

    // reset, start with leds=0 is ignored
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check("zero_start_state", 32'(state0), 32'd0);

    // rst and load on the same edge mid-RUN
    step(1'b0, 1'b1, 8'd7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 1'b1, 8'd7, 1'b0, 1'b0);
    check("rst_over_load", 32'(bus0.leds), 32'd0);

    // MAX_COUNT=1: 255 down to 0 without wrap
    step(1'b0, 1'b1, 8'd255, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    idle(254);
    check("m1_254", 32'(bus1.leds), 32'd1);
    idle(1);
    check("m1_zero", 32'(bus1.leds), 32'd0);
    check("m1_done", 32'(bus1.done), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      check("m1_no_wrap", 32'(bus1.leds), 32'd0);
    end

    // randomized mix
    for (int i = 0; i < 400; i++) begin
      logic r, l, s, p;
      logic [7:0] v;
      r = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      step(r, l, v, s, p);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
